// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: byte-lane load/store on an internal
// word array with fixed latency, sign/zero-extended loads and a pipeline stall.
module dmem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        REQ,
   input  logic        WE,
   input  logic [31:0] ADDR,
   input  logic [31:0] WDATA,
   input  logic [3:0]  BE,
   input  logic        UNSIGNED,
   output logic        READY,
   output logic        RVALID,
   output logic [31:0] RDATA,
   output logic        ERR,
   output logic        STALL
);

   localparam int         DEPTH  = 2 ** ADDR_WIDTH;
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   state_t                state_r, state_s;
   logic [3:0]            cnt_r;
   logic [ADDR_WIDTH+1:0] addr_r, a_s;
   logic                  we_r, w_s, uns_r, u_s;
   logic [31:0]           wdata_r, wd_s;
   logic [3:0]            be_r, b_s;
   logic                  rvalid_r, err_r;
   logic [31:0]           rdata_r;
   logic [31:0]           mem_r [DEPTH];

   logic [1:0]            off_s;
   logic [ADDR_WIDTH-1:0] idx_s;
   logic [3:0]            mask_s;
   logic [31:0]           wsh_s, raw_s, rdata_s;
   logic                  err_s, access_s;
   logic                  unused_addr_s;

   function automatic logic access_error(input logic [3:0] be, input logic [1:0] off);
      logic bad;
      case (be)
         4'b0001: bad = 1'b0;
         4'b0011: bad = off[0];
         4'b1111: bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [3:0] be,
                                               input logic uns);
      logic [31:0] v;
      case (be)
         4'b0001: v = uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
         4'b0011: v = uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
         default: v = raw;
      endcase
      return v;
   endfunction

   assign unused_addr_s = ^ADDR[31:ADDR_WIDTH+2];

   // Operand select: with LATENCY==1 the access uses the live request in IDLE.
   always_comb begin
      if (state_r == IDLE) begin
         a_s  = ADDR[ADDR_WIDTH+1:0];
         w_s  = WE;
         wd_s = WDATA;
         b_s  = BE;
         u_s  = UNSIGNED;
      end else begin
         a_s  = addr_r;
         w_s  = we_r;
         wd_s = wdata_r;
         b_s  = be_r;
         u_s  = uns_r;
      end
   end

   // Lane mapping, error detection and load extension for the selected access.
   always_comb begin
      off_s    = a_s[1:0];
      idx_s    = a_s[ADDR_WIDTH+1:2];
      mask_s   = b_s << off_s;
      wsh_s    = wd_s << {off_s, 3'b000};
      raw_s    = mem_r[idx_s] >> {off_s, 3'b000};
      err_s    = access_error(b_s, off_s);
      rdata_s  = (w_s || err_s) ? 32'd0 : extend_load(raw_s, b_s, u_s);
      // cnt_r counts remaining WAIT cycles including the current one.
      access_s = RSTn && (((state_r == IDLE) && REQ && (LATENCY == 1)) ||
                          ((state_r == WAIT) && (cnt_r == 4'd1)));
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (REQ) state_s = (LATENCY == 1) ? RESP : WAIT;
            else     state_s = IDLE;
         end
         WAIT: begin
            if (cnt_r == 4'd1) state_s = RESP;
            else               state_s = WAIT;
         end
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State, latency counter, request latches and registered response.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_r  <= IDLE;
         cnt_r    <= 4'd0;
         addr_r   <= '0;
         we_r     <= 1'b0;
         wdata_r  <= 32'd0;
         be_r     <= 4'd0;
         uns_r    <= 1'b0;
         rvalid_r <= 1'b0;
         rdata_r  <= 32'd0;
         err_r    <= 1'b0;
      end else begin
         state_r  <= state_s;
         rvalid_r <= access_s;
         if (access_s) begin
            rdata_r <= rdata_s;
            err_r   <= err_s;
         end
         if ((state_r == IDLE) && REQ) begin
            cnt_r   <= LAT_M1;
            addr_r  <= ADDR[ADDR_WIDTH+1:0];
            we_r    <= WE;
            wdata_r <= WDATA;
            be_r    <= BE;
            uns_r   <= UNSIGNED;
         end else if (state_r == WAIT) begin
            cnt_r <= cnt_r - 4'd1;
         end
      end
   end

   // Byte-lane store into the array; the array itself is never reset.
   always_ff @(posedge CLK) begin
      if (access_s && w_s && !err_s) begin
         for (int i = 0; i < 4; i++) begin
            if (mask_s[i]) mem_r[idx_s][8*i +: 8] <= wsh_s[8*i +: 8];
         end
      end
   end

   assign READY  = (state_r == IDLE);
   assign STALL  = ((state_r == IDLE) && REQ) || (state_r == WAIT);
   assign RVALID = rvalid_r;
   assign RDATA  = rdata_r;
   assign ERR    = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// accesses compared against a byte-array reference model.
module tb_dmem_responder;

   localparam int AW    = 10;
   localparam int LAT   = 2;
   localparam int DEPTH = 1 << AW;

   logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0, uns = 1'b0;
   logic [31:0] addr = 32'd0, wdata = 32'd0;
   logic [3:0]  be = 4'd0;
   logic        ready, rvalid, err, stall;
   logic [31:0] rdata;

   int passed = 0, total = 0, failed = 0;
   logic [7:0]  ref_mem [0:4*DEPTH-1];
   logic [31:0] last_d = 32'd0;
   logic        last_e = 1'b0;

   dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
      .CLK(clk), .RSTn(rst_n), .REQ(req), .WE(we), .ADDR(addr), .WDATA(wdata),
      .BE(be), .UNSIGNED(uns), .READY(ready), .RVALID(rvalid), .RDATA(rdata),
      .ERR(err), .STALL(stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: aligned access of 1/2/4 bytes on a byte array, address modulo array size.
   task automatic model(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] b, input logic u,
                        output logic [31:0] ed, output logic ee);
      int unsigned size, base;
      logic [31:0] v;
      case (b)
         4'b0001: size = 1;
         4'b0011: size = 2;
         4'b1111: size = 4;
         default: size = 0;
      endcase
      ee = (size == 0) ? 1'b1 : ((a % size) != 0);
      v  = 32'd0;
      if (!ee) begin
         base = a % (4 * DEPTH);
         for (int i = 0; i < size; i++)
            if (w) ref_mem[base+i] = d[8*i +: 8];
            else   v = v | (32'(ref_mem[base+i]) << (8*i));
         if (!w && !u && size < 4 && v[8*size-1]) v = v | (32'hFFFFFFFF << (8*size));
      end
      ed = w ? 32'd0 : v;
   endtask

   task automatic do_op(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] b, input logic u, input logic hold);
      logic [31:0] ed;
      logic        ee;
      @(negedge clk);
      chk("ready_idle",  ready,  32'd1);
      chk("rvalid_idle", rvalid, 32'd0);
      chk("rdata_hold",  rdata,  last_d);
      chk("err_hold",    err,    32'(last_e));
      req = 1'b1; we = w; addr = a; wdata = d; be = b; uns = u;
      #1;
      chk("stall_accept", stall, 32'd1);
      model(a, w, d, b, u, ed, ee);
      @(posedge clk);
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         if (!hold) req = 1'b0;
         #1;
         chk("ready_busy", ready,  32'd0);
         chk("rvalid_t",   rvalid, (k == LAT) ? 32'd1 : 32'd0);
         chk("stall_t",    stall,  (k < LAT) ? 32'd1 : 32'd0);
         if (k == LAT) begin
            chk("rdata", rdata, ed);
            chk("err",   err,   32'(ee));
         end
      end
      last_d = ed;
      last_e = ee;
   endtask

   initial begin
      logic [31:0] ra, rd;
      logic [3:0]  rb;
      #2;
      chk("rst_ready",  ready,  32'd1);
      chk("rst_rvalid", rvalid, 32'd0);
      chk("rst_rdata",  rdata,  32'd0);
      chk("rst_err",    err,    32'd0);
      chk("rst_stall0", stall,  32'd0);
      req = 1'b1; #1;
      chk("rst_stall1", stall,  32'd1);
      req = 1'b0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Word store/load
      do_op(32'h10, 1'b1, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0);
      do_op(32'h10, 1'b0, 32'h0, 4'b1111, 1'b0, 1'b0);
      // Byte store and signed/unsigned byte loads
      do_op(32'h10, 1'b1, 32'h11223344, 4'b1111, 1'b0, 1'b0);
      do_op(32'h13, 1'b1, 32'h000000AA, 4'b0001, 1'b0, 1'b0);
      do_op(32'h10, 1'b0, 32'h0, 4'b1111, 1'b0, 1'b0);
      do_op(32'h13, 1'b0, 32'h0, 4'b0001, 1'b0, 1'b0);
      do_op(32'h13, 1'b0, 32'h0, 4'b0001, 1'b1, 1'b0);
      // Half store and loads; lower half must survive
      do_op(32'h20, 1'b1, 32'hCAFEBABE, 4'b1111, 1'b0, 1'b0);
      do_op(32'h22, 1'b1, 32'h00008001, 4'b0011, 1'b0, 1'b0);
      do_op(32'h22, 1'b0, 32'h0, 4'b0011, 1'b0, 1'b0);
      do_op(32'h22, 1'b0, 32'h0, 4'b0011, 1'b1, 1'b0);
      do_op(32'h20, 1'b0, 32'h0, 4'b0011, 1'b1, 1'b0);
      // Misaligned and illegal-BE accesses leave memory untouched
      do_op(32'h04, 1'b1, 32'h01020304, 4'b1111, 1'b0, 1'b0);
      do_op(32'h05, 1'b1, 32'hFFFFFFFF, 4'b1111, 1'b0, 1'b0);
      do_op(32'h03, 1'b0, 32'h0, 4'b0011, 1'b0, 1'b0);
      do_op(32'h04, 1'b1, 32'hFFFFFFFF, 4'b0101, 1'b0, 1'b0);
      do_op(32'h04, 1'b0, 32'h0, 4'b1111, 1'b0, 1'b0);
      // Back-to-back loads with REQ held high
      do_op(32'h10, 1'b0, 32'h0, 4'b1111, 1'b0, 1'b1);
      do_op(32'h20, 1'b0, 32'h0, 4'b1111, 1'b0, 1'b0);

      // Reset during WAIT of a store aborts it
      do_op(32'h40, 1'b1, 32'h12345678, 4'b1111, 1'b0, 1'b0);
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'hFFFFFFFF; be = 4'b1111;
      @(posedge clk);
      @(negedge clk);
      chk("wait_stall", stall, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_ready",  ready,  32'd1);
      chk("arst_rvalid", rvalid, 32'd0);
      chk("arst_rdata",  rdata,  32'd0);
      chk("arst_err",    err,    32'd0);
      chk("arst_stall",  stall,  32'd1);
      req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      last_d = 32'd0;
      last_e = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("no_rvalid", rvalid, 32'd0);
      end
      do_op(32'h40, 1'b0, 32'h0, 4'b1111, 1'b0, 1'b0);
      do_op(32'h40 + 4*DEPTH, 1'b0, 32'h0, 4'b1111, 1'b0, 1'b0);
      do_op(32'h40 + 8*DEPTH, 1'b1, 32'hA5A55A5A, 4'b1111, 1'b0, 1'b0);
      do_op(32'h40, 1'b0, 32'h0, 4'b1111, 1'b0, 1'b0);

      // Randomized accesses over an initialized region
      for (int i = 0; i < 16; i++)
         do_op(32'h200 + 4*i, 1'b1, $urandom, 4'b1111, 1'b0, 1'b0);
      for (int i = 0; i < 60; i++) begin
         ra = 32'h200 + $urandom_range(0, 63) + 4 * DEPTH * $urandom_range(0, 3);
         case ($urandom_range(0, 3))
            0:       rb = 4'b0001;
            1:       rb = 4'b0011;
            2:       rb = 4'b1111;
            default: rb = 4'($urandom_range(0, 15));
         endcase
         rd = $urandom;
         do_op(ra, 1'($urandom_range(0, 1)), rd, rb, 1'($urandom_range(0, 1)),
               (i != 59) ? 1'($urandom_range(0, 1)) : 1'b0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
